// File: rtl/m_ingress_arb.sv
// m_ingress_arb: per-channel framed ingress FIFOs feeding a
// round-robin, packet-atomic egress arbiter without backpressure.
module m_ingress_arb #(
   parameter int CH_N       = 4,
   parameter int DATA_W     = 64,
   parameter int LEN_W      = 16,
   parameter int FIFO_DEPTH = 8,
   localparam int CH_W      = (CH_N > 1) ? $clog2(CH_N) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [CH_N-1:0]          in_vld_w,
   input  logic [CH_N-1:0]          in_sop_w,
   input  logic [CH_N-1:0]          in_eop_w,
   input  logic [CH_N*LEN_W-1:0]    in_length_w,
   input  logic [CH_N*DATA_W-1:0]   in_data_w,
   output logic [CH_N-1:0]          in_rdy_r,
   output logic                     out_vld_r,
   output logic                     out_sop_r,
   output logic                     out_eop_r,
   output logic [LEN_W-1:0]         out_length_r,
   output logic [DATA_W-1:0]        out_data_r,
   output logic [CH_W-1:0]          out_ch_r,
   output logic [CH_N-1:0]          err_r
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int ENT_W = 2 + LEN_W + DATA_W;
   localparam logic [PTR_W:0] FULL = (PTR_W+1)'(FIFO_DEPTH);

   typedef enum logic {IDLE, XFER} state_t;

   state_t           state_r, state_nxt;
   logic [ENT_W-1:0] mem [CH_N][FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_r [CH_N];
   logic [PTR_W-1:0] rd_ptr_r [CH_N];
   logic [PTR_W:0]   cnt_r [CH_N];
   logic [PTR_W:0]   cnt_nxt [CH_N];
   logic [CH_N-1:0]  in_pkt_r, acc, legal, bad, pop, busy;
   logic [CH_W-1:0]  grant_r, last_r, rr_ch, pop_ch, cand;
   logic [CH_W:0]    sum;
   logic             rr_hit, pop_en, gap_r;
   logic [ENT_W-1:0] head;

   // a beat is legal when its sop matches "not inside a packet"
   always_comb begin
      for (int c = 0; c < CH_N; c++) begin
         acc[c]   = in_vld_w[c] & in_rdy_r[c];
         legal[c] = acc[c] & (in_sop_w[c] ^ in_pkt_r[c]);
         bad[c]   = acc[c] & ~legal[c];
         busy[c]  = cnt_r[c] != '0;
      end
   end

   always_comb begin
      rr_hit = 1'b0;
      rr_ch  = '0;
      sum    = '0;
      cand   = '0;
      for (int i = CH_N; i >= 1; i--) begin
         sum = {1'b0, last_r} + (CH_W+1)'(i);
         if (sum >= (CH_W+1)'(CH_N))
            sum = sum - (CH_W+1)'(CH_N);
         cand = sum[CH_W-1:0];
         if (busy[cand]) begin
            rr_hit = 1'b1;
            rr_ch  = cand;
         end
      end
   end

   always_comb begin
      state_nxt = state_r;
      pop_en    = 1'b0;
      pop_ch    = grant_r;
      unique case (state_r)
         IDLE: begin
            if (rr_hit && !gap_r) begin
               pop_en = 1'b1;
               pop_ch = rr_ch;
            end
         end
         XFER: pop_en = busy[grant_r];
         default: ;
      endcase
      head = mem[pop_ch][rd_ptr_r[pop_ch]];
      if (pop_en)
         state_nxt = head[ENT_W-2] ? IDLE : XFER;
      for (int c = 0; c < CH_N; c++)
         pop[c] = pop_en && (pop_ch == CH_W'(c));
   end

   always_comb begin
      for (int c = 0; c < CH_N; c++)
         cnt_nxt[c] = cnt_r[c]
                    + (PTR_W+1)'(legal[c])
                    - (PTR_W+1)'(pop[c]);
   end

   always_ff @(posedge clk) begin
      for (int c = 0; c < CH_N; c++)
         if (legal[c])
            mem[c][wr_ptr_r[c]] <= {in_sop_w[c], in_eop_w[c],
                                    in_length_w[c*LEN_W +: LEN_W],
                                    in_data_w[c*DATA_W +: DATA_W]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < CH_N; c++) begin
            wr_ptr_r[c] <= '0;
            rd_ptr_r[c] <= '0;
            cnt_r[c]    <= '0;
         end
         in_pkt_r <= '0;
         in_rdy_r <= '0;
         err_r    <= '0;
      end else begin
         for (int c = 0; c < CH_N; c++) begin
            cnt_r[c]    <= cnt_nxt[c];
            in_rdy_r[c] <= cnt_nxt[c] < FULL;
            if (legal[c]) begin
               wr_ptr_r[c] <= wr_ptr_r[c] + PTR_W'(1);
               in_pkt_r[c] <= ~in_eop_w[c];
            end
            if (pop[c])
               rd_ptr_r[c] <= rd_ptr_r[c] + PTR_W'(1);
         end
         err_r <= bad;
      end
   end

   // gap_r forces one idle cycle after every packet end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         grant_r      <= '0;
         last_r       <= CH_W'(CH_N-1);
         gap_r        <= 1'b0;
         out_vld_r    <= 1'b0;
         out_sop_r    <= 1'b0;
         out_eop_r    <= 1'b0;
         out_length_r <= '0;
         out_data_r   <= '0;
         out_ch_r     <= '0;
      end else begin
         state_r   <= state_nxt;
         gap_r     <= pop_en & head[ENT_W-2];
         out_vld_r <= pop_en;
         if (pop_en) begin
            {out_sop_r, out_eop_r, out_length_r, out_data_r} <= head;
            out_ch_r <= pop_ch;
         end
         if (state_r == IDLE && pop_en) begin
            grant_r <= pop_ch;
            last_r  <= pop_ch;
         end
      end
   end

endmodule

// File: tb/tb_m_ingress_arb.sv
// tb_m_ingress_arb: scoreboard bench with a queue-level model of
// framing, round-robin packet arbitration and FIFO backpressure.
module tb_m_ingress_arb;

   localparam int CH_N   = 4;
   localparam int DATA_W = 64;
   localparam int LEN_W  = 16;
   localparam int DEPTH  = 8;
   localparam int CH_W   = 2;

   typedef struct {
      logic              vld;
      logic              sop;
      logic              eop;
      logic [LEN_W-1:0]  len;
      logic [DATA_W-1:0] data;
      int                we;
   } beat_t;

   logic                   clk;
   logic                   rst;
   logic [CH_N-1:0]        in_vld_w, in_sop_w, in_eop_w;
   logic [CH_N*LEN_W-1:0]  in_length_w;
   logic [CH_N*DATA_W-1:0] in_data_w;
   logic [CH_N-1:0]        in_rdy_r;
   logic                   out_vld_r, out_sop_r, out_eop_r;
   logic [LEN_W-1:0]       out_length_r;
   logic [DATA_W-1:0]      out_data_r;
   logic [CH_W-1:0]        out_ch_r;
   logic [CH_N-1:0]        err_r;

   m_ingress_arb #(
      .CH_N(CH_N), .DATA_W(DATA_W),
      .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .in_vld_w(in_vld_w), .in_sop_w(in_sop_w),
      .in_eop_w(in_eop_w), .in_length_w(in_length_w),
      .in_data_w(in_data_w), .in_rdy_r(in_rdy_r),
      .out_vld_r(out_vld_r), .out_sop_r(out_sop_r),
      .out_eop_r(out_eop_r), .out_length_r(out_length_r),
      .out_data_r(out_data_r), .out_ch_r(out_ch_r),
      .err_r(err_r)
   );

   int n_chk = 0;
   int n_fail = 0;
   int edge_cnt = 0;

   beat_t sq[CH_N][$];
   beat_t mq[CH_N][$];
   bit [CH_N-1:0] pres = '0;
   logic [CH_N-1:0] rdy_s;
   logic [CH_N-1:0] in_pkt_m = '0;
   logic [CH_N-1:0] err_hist [4];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      edge_cnt++;
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @edge %0d: got %0h expected %0h",
                  nm, edge_cnt, act, exp);
      end
   endtask

   function automatic beat_t mk(bit v, bit s, bit e,
                                logic [15:0] l, logic [63:0] d);
      beat_t t;
      t.vld = v; t.sop = s; t.eop = e;
      t.len = l; t.data = d; t.we = 0;
      return t;
   endfunction

   // driver: presents each channel's head item, pops on accept or gap
   initial begin
      in_vld_w = '0; in_sop_w = '0; in_eop_w = '0;
      in_length_w = '0; in_data_w = '0;
      forever begin
         @(negedge clk);
         rdy_s = in_rdy_r;
         @(posedge clk);
         #1;
         for (int c = 0; c < CH_N; c++) begin
            if (pres[c] && sq[c].size() > 0)
               if (!sq[c][0].vld || rdy_s[c])
                  void'(sq[c].pop_front());
            if (sq[c].size() > 0) begin
               in_vld_w[c] = sq[c][0].vld;
               in_sop_w[c] = sq[c][0].sop;
               in_eop_w[c] = sq[c][0].eop;
               in_length_w[c*LEN_W +: LEN_W] = sq[c][0].len;
               in_data_w[c*DATA_W +: DATA_W] = sq[c][0].data;
               pres[c] = 1'b1;
            end else begin
               in_vld_w[c] = 1'b0;
               pres[c] = 1'b0;
            end
         end
      end
   end

   // ingress model: framing rules decide what is stored or flagged
   int n1;
   logic [CH_N-1:0] e_m;
   beat_t nb;
   initial begin
      for (int i = 0; i < 4; i++) err_hist[i] = '0;
      forever begin
         @(negedge clk);
         n1 = edge_cnt + 1;
         e_m = '0;
         if (rst) begin
            in_pkt_m = '0;
         end else begin
            for (int c = 0; c < CH_N; c++) begin
               if (in_vld_w[c] && in_rdy_r[c]) begin
                  if (in_pkt_m[c] ? !in_sop_w[c] : in_sop_w[c]) begin
                     nb = mk(1, in_sop_w[c], in_eop_w[c],
                             in_length_w[c*LEN_W +: LEN_W],
                             in_data_w[c*DATA_W +: DATA_W]);
                     nb.we = n1;
                     mq[c].push_back(nb);
                     if (in_eop_w[c]) in_pkt_m[c] = 1'b0;
                     else if (in_sop_w[c]) in_pkt_m[c] = 1'b1;
                  end else begin
                     e_m[c] = 1'b1;
                  end
               end
            end
         end
         err_hist[n1 % 4] = e_m;
      end
   end

   function automatic bit elig(int c, int n);
      return mq[c].size() > 0 && mq[c][0].we < n;
   endfunction

   // monitor: predicts each egress cycle from the model queues
   int n, exp_ch, cur, last_m, occ, cc;
   bit exp_vld, active, prev_eop;
   bit rst_q = 1'b1;
   beat_t b;
   logic h_sop, h_eop;
   logic [DATA_W-1:0] h_data;
   logic [CH_W-1:0] h_ch;
   initial begin
      active = 0; prev_eop = 0; cur = 0; last_m = CH_N-1;
      h_sop = 0; h_eop = 0; h_data = '0; h_ch = '0;
      forever begin
         @(negedge clk);
         n = edge_cnt;
         if (rst_q) begin
            chk("rst_vld", out_vld_r, 0);
            chk("rst_sop", out_sop_r, 0);
            chk("rst_eop", out_eop_r, 0);
            chk("rst_len", out_length_r, 0);
            chk("rst_data", out_data_r, 0);
            chk("rst_ch", out_ch_r, 0);
            chk("rst_rdy", in_rdy_r, 0);
            chk("rst_err", err_r, 0);
            for (int c = 0; c < CH_N; c++) mq[c].delete();
            active = 0; prev_eop = 0; last_m = CH_N-1;
            h_sop = 0; h_eop = 0; h_data = '0; h_ch = '0;
         end else begin
            exp_vld = 0;
            exp_ch = cur;
            if (prev_eop) begin
               exp_vld = 0;
            end else if (active) begin
               exp_vld = elig(cur, n);
            end else begin
               for (int i = 1; i <= CH_N; i++) begin
                  cc = (last_m + i) % CH_N;
                  if (!exp_vld && elig(cc, n)) begin
                     exp_vld = 1;
                     exp_ch = cc;
                  end
               end
            end
            chk("out_vld", out_vld_r, exp_vld);
            if (out_vld_r && exp_vld) begin
               b = mq[exp_ch].pop_front();
               chk("out_ch", out_ch_r, exp_ch);
               chk("out_sop", out_sop_r, b.sop);
               chk("out_eop", out_eop_r, b.eop);
               chk("out_data", out_data_r, b.data);
               if (b.sop) chk("out_len", out_length_r, b.len);
               if (!active) last_m = exp_ch;
               cur = exp_ch;
               active = !b.eop;
               prev_eop = b.eop;
               h_sop = b.sop; h_eop = b.eop;
               h_data = b.data; h_ch = CH_W'(exp_ch);
            end else begin
               prev_eop = 0;
               if (!out_vld_r) begin
                  chk("hold_data", out_data_r, h_data);
                  chk("hold_ch", out_ch_r, h_ch);
                  chk("hold_flags", {out_sop_r, out_eop_r},
                      {h_sop, h_eop});
               end
            end
            chk("err", err_r, err_hist[n % 4]);
            for (int c = 0; c < CH_N; c++) begin
               occ = 0;
               for (int j = 0; j < mq[c].size(); j++)
                  if (mq[c][j].we <= n) occ++;
               chk("in_rdy", in_rdy_r[c], occ < DEPTH);
            end
         end
         rst_q = rst;
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic flush();
      for (int c = 0; c < CH_N; c++) sq[c].delete();
      pres = '0;
   endtask

   task automatic drain(input string nm, input int budget);
      int k;
      k = 0;
      while ((sq[0].size() + sq[1].size() + sq[2].size()
              + sq[3].size()) != 0 && k < budget) begin
         step();
         k++;
      end
      n_chk++;
      if (k >= budget) begin
         n_fail++;
         $display("FAIL %s: stimulus not consumed in %0d cycles",
                  nm, budget);
         flush();
      end
      repeat (40) step();
   endtask

   task automatic pkt(input int c, input int nb, input int base);
      for (int k = 0; k < nb; k++)
         sq[c].push_back(mk(1, k == 0, k == nb-1, 16'(nb),
                            64'(base + k)));
   endtask

   task automatic rnd_pkts(input int np);
      for (int c = 0; c < CH_N; c++)
         for (int p = 0; p < np; p++) begin
            int nbt;
            nbt = $urandom_range(1, 4);
            for (int k = 0; k < nbt; k++) begin
               bit s, e;
               s = (k == 0);
               e = (k == nbt-1);
               if ((k == 0 || k < nbt-1) && $urandom_range(0, 15) == 0)
                  s = !s;
               if ($urandom_range(0, 3) == 0)
                  sq[c].push_back(mk(0, 0, 0, 0, 0));
               sq[c].push_back(mk(1, s, e, 16'($urandom),
                                  {$urandom, $urandom}));
            end
         end
   endtask

   int k;
   initial begin
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      step();

      sq[2].push_back(mk(1, 1, 1, 16'd8, 64'hA5));
      drain("single_beat", 50);

      pkt(0, 3, 'h100);
      pkt(1, 3, 'h200);
      drain("two_ch", 80);

      pkt(0, 1, 'h300);
      sq[0][0].eop = 1'b0;
      repeat (30) sq[0].push_back(mk(0, 0, 0, 0, 0));
      sq[0].push_back(mk(1, 0, 1, 16'd2, 64'h301));
      repeat (3) step();
      pkt(3, 12, 'h400);
      drain("backpressure", 200);

      sq[1].push_back(mk(1, 0, 0, 16'd1, 64'h500));
      sq[1].push_back(mk(0, 0, 0, 0, 0));
      sq[1].push_back(mk(1, 1, 0, 16'd3, 64'h501));
      sq[1].push_back(mk(1, 1, 0, 16'd3, 64'h502));
      sq[1].push_back(mk(1, 0, 1, 16'd3, 64'h503));
      drain("framing_err", 80);

      sq[0].push_back(mk(1, 1, 0, 16'd4, 64'h600));
      sq[0].push_back(mk(1, 0, 0, 16'd4, 64'h601));
      repeat (3) sq[0].push_back(mk(0, 0, 0, 0, 0));
      sq[0].push_back(mk(1, 0, 0, 16'd4, 64'h602));
      sq[0].push_back(mk(1, 0, 1, 16'd4, 64'h603));
      pkt(1, 2, 'h700);
      drain("gap_hold", 80);

      pkt(0, 5, 'h800);
      k = 0;
      while (sq[0].size() > 3 && k < 100) begin
         step();
         k++;
      end
      n_chk++;
      if (k >= 100) begin
         n_fail++;
         $display("FAIL mid_reset: beats not accepted in time");
      end
      rst = 1'b1;
      flush();
      repeat (2) step();
      rst = 1'b0;
      repeat (10) step();

      for (int r = 0; r < 4; r++) begin
         rnd_pkts(6);
         drain("random", 3000);
      end

      chk("model_empty", mq[0].size() + mq[1].size()
          + mq[2].size() + mq[3].size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
